// File: rtl/fmap_pkg.sv
// fmap_pkg: shared width, FP16 constants, FSM encoding and helpers for the feature-map stream blocks
package fmap_pkg;
  localparam int DATA_WIDTH = 16;
  localparam logic [DATA_WIDTH-1:0] FP16_ZERO = 16'h0000;
  localparam logic [DATA_WIDTH-1:0] FP16_ONE = 16'h3C00;
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fmap_idx_counter.sv
// fmap_idx_counter: nested col/row/ch tensor index counter with load and wrap flags
module fmap_idx_counter #(
  parameter int H = 2,
  parameter int W = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_ch,
  input  logic             advance,
  output logic [CNT_W-1:0] ch,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             col_wrap,
  output logic             row_wrap
);
  assign col_wrap = col == CNT_W'(W - 1);
  assign row_wrap = col_wrap && row == CNT_W'(H - 1);
  // load starts a channel at (load_ch,0,0); advance steps col, then row, then ch
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ch  <= '0;
      row <= '0;
      col <= '0;
    end else if (load) begin
      ch  <= load_ch;
      row <= '0;
      col <= '0;
    end else if (advance) begin
      col <= col_wrap ? '0 : col + CNT_W'(1);
      row <= row_wrap ? '0 : col_wrap ? row + CNT_W'(1) : row;
      ch  <= row_wrap ? ch + CNT_W'(1) : ch;
    end
endmodule

// File: rtl/fmap_stream_reader.sv
// fmap_stream_reader: captures a flat FP16 tensor and streams it word by word (channel window via FMAP_STREAM_CHSEL_EN)
module fmap_stream_reader
  import fmap_pkg::*;
#(
  parameter int D = 2,
  parameter int H = 2,
  parameter int W = 2,
  parameter int CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [0:D*H*W*DATA_WIDTH-1] x,
  input  logic                        start,
`ifdef FMAP_STREAM_CHSEL_EN
  input  logic [CNT_W-1:0]            ch_first,
  input  logic [CNT_W-1:0]            ch_count,
`endif
  output logic                        busy,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [CNT_W-1:0]            m_ch,
  output logic [CNT_W-1:0]            m_row,
  output logic [CNT_W-1:0]            m_col,
  output logic                        m_last_row,
  output logic                        m_last_ch,
  output logic                        m_last,
  output logic                        done
);
  localparam int N = D * H * W * DATA_WIDTH;
  localparam int CH_BITS = H * W * DATA_WIDTH;
  state_t state, state_n;
  logic [0:N-1] shadow;
  logic [CNT_W-1:0] first, ch_end, ch_last;
  logic col_wrap, row_wrap, accept, hs, fin, empty, done_n;
`ifdef FMAP_STREAM_CHSEL_EN
  logic [CNT_W-1:0] avail, eff;
  assign avail = ch_first < CNT_W'(D) ? CNT_W'(D) - ch_first : '0;
  assign eff = ch_count > avail ? avail : ch_count;
  assign first = ch_first;
  assign empty = eff == '0;
  assign ch_end = ch_first + eff - CNT_W'(1);
`else
  assign first = '0;
  assign empty = 1'b0;
  assign ch_end = CNT_W'(D - 1);
`endif
  assign m_valid = state == STREAM;
  assign busy = m_valid;
  assign m_data = shadow[0:DATA_WIDTH-1];
  assign m_last_row = m_valid && col_wrap;
  assign m_last_ch = m_valid && row_wrap;
  assign m_last = m_last_ch && m_ch == ch_last;
  fmap_idx_counter #(.H(H), .W(W), .CNT_W(CNT_W)) u_idx (
    .clk(clk), .reset(reset), .load(accept), .load_ch(first), .advance(hs),
    .ch(m_ch), .row(m_row), .col(m_col), .col_wrap(col_wrap), .row_wrap(row_wrap)
  );
  // next state: an empty window finishes immediately without entering STREAM
  always_comb begin
    accept = state == IDLE && start;
    hs = m_valid && m_ready;
    fin = hs && m_last;
    state_n = accept && !empty ? STREAM : fin ? IDLE : state;
    done_n = (accept && empty) || fin;
  end
  // state, done pulse, end channel and shadow tensor; head word is always at the top of the shadow
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      ch_last <= '0;
      shadow  <= '0;
    end else begin
      state <= state_n;
      done  <= done_n;
      if (accept) begin
        ch_last <= ch_end;
        shadow  <= x << (first * CH_BITS);
      end else if (hs) shadow <= shadow << DATA_WIDTH;
    end
endmodule

// File: tb/tb_fmap_stream_reader.sv
// tb_fmap_stream_reader: scoreboard bench for fmap_stream_reader (channel window tests under FMAP_STREAM_CHSEL_EN)
module tb_fmap_stream_reader;
  import fmap_pkg::*;
`ifdef FMAP_STREAM_CHSEL_EN
  localparam int D = 4;
`else
  localparam int D = 2;
`endif
  localparam int H = 2, W = 2, CNT_W = 8, NW = D * H * W;
  typedef struct packed {
    logic [15:0] d;
    logic [7:0] ch, row, col;
    logic lr, lc, l;
  } exp_t;
  logic clk = 0, reset = 1, start = 0, m_ready = 0;
  logic [0:NW*16-1] x = '0;
`ifdef FMAP_STREAM_CHSEL_EN
  logic [CNT_W-1:0] ch_first = '0, ch_count = 8'd2;
`endif
  logic busy, m_valid, m_last_row, m_last_ch, m_last, done;
  logic [15:0] m_data;
  logic [CNT_W-1:0] m_ch, m_row, m_col;
  exp_t q[$];
  exp_t cur, prev;
  logic [15:0] wv[16];
  int n_chk = 0, n_fail = 0, hs_cnt = 0;
  bit stall_prev = 0, ok;
  int pat[4] = '{1, 0, 0, 1};

  fmap_stream_reader #(.D(D), .H(H), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .x(x), .start(start),
`ifdef FMAP_STREAM_CHSEL_EN
    .ch_first(ch_first), .ch_count(ch_count),
`endif
    .busy(busy), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_ch(m_ch), .m_row(m_row), .m_col(m_col), .m_last_row(m_last_row),
    .m_last_ch(m_last_ch), .m_last(m_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int k, input int last, input logic [15:0] xr);
    exp_t e;
    e.d = wv[k] ^ xr;
    e.ch = 8'(k / 4);
    e.row = 8'((k / 2) % 2);
    e.col = 8'(k % 2);
    e.lr = k % 2 == 1;
    e.lc = k % 4 == 3;
    e.l = k == last;
    return e;
  endfunction

  assign cur = '{d: m_data, ch: m_ch, row: m_row, col: m_col, lr: m_last_row, lc: m_last_ch, l: m_last};

  // monitor: pops expectations on handshakes and checks stability under backpressure
  always @(negedge clk) begin
    if (reset) stall_prev = 0;
    else begin
      if (stall_prev) check("stall_hold", {m_valid, cur}, {1'b1, prev});
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_word: got %0h expected none at %0t", cur, $time);
        end else check("word", cur, q.pop_front());
      end
      stall_prev = m_valid && !m_ready;
      prev = cur;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] xr);
    for (int k = 0; k < NW; k++) x[k*16 +: 16] = wv[k] ^ xr;
  endtask

  task automatic frame(input logic [15:0] xr, input int first_k, input int last_k);
    load(xr);
    for (int k = first_k; k <= last_k; k++) q.push_back(mk(k, last_k, xr));
    start = 1;
    tick(1);
    start = 0;
  endtask

  task automatic wait_done(input int lim, output bit seen);
    seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      tick(1);
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wv = '{FP16_ONE, 16'h3E00, 16'h4000, 16'h4100, 16'h4200, 16'h4300, 16'h4400, 16'h4500,
           16'h4600, 16'h4700, 16'h4800, 16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80};
    #12;
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", m_data, FP16_ZERO);
    check("rst_flags", {m_last_row, m_last_ch, m_last}, 0);
    @(posedge clk);
    #1 reset = 0;
    m_ready = 1;
    // basic frame at full rate: done exactly one cycle after word 7
    hs_cnt = 0;
    frame(16'h0000, 0, 7);
    check("valid_after_start", m_valid, 1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_low", busy, 0);
    check("valid_low", m_valid, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("basic_count", hs_cnt, 8);
    check("basic_q_empty", q.size(), 0);
    // backpressure 1,0,0,1
    tick(1);
    hs_cnt = 0;
    frame(16'h0000, 0, 7);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      m_ready = pat[i % 4][0];
      tick(1);
      if (done) ok = 1;
    end
    check("bp_done_seen", ok, 1);
    check("bp_count", hs_cnt, 8);
    check("bp_q_empty", q.size(), 0);
    m_ready = 1;
    tick(2);
    // start mid-frame with new x is ignored; start in done cycle begins a new frame
    hs_cnt = 0;
    frame(16'h0000, 0, 7);
    tick(3);
    load(16'h8000);
    start = 1;
    tick(1);
    start = 0;
    wait_done(50, ok);
    for (int k = 0; k < 8; k++) q.push_back(mk(k, 7, 16'h8000));
    start = 1;
    tick(1);
    start = 0;
    check("restart_valid", m_valid, 1);
    check("restart_data", m_data, wv[0] ^ 16'h8000);
    wait_done(50, ok);
    check("ign_count", hs_cnt, 16);
    check("ign_q_empty", q.size(), 0);
    tick(2);
    // asynchronous reset on the third word
    hs_cnt = 0;
    frame(16'h0000, 0, 7);
    tick(2);
    #2 reset = 1;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_count", hs_cnt, 2);
    q.delete();
    tick(1);
    reset = 0;
    hs_cnt = 0;
    frame(16'h8000, 0, 7);
    wait_done(50, ok);
    check("post_rst_count", hs_cnt, 8);
    check("post_rst_q_empty", q.size(), 0);
    tick(2);
`ifdef FMAP_STREAM_CHSEL_EN
    // channel window 2..3
    ch_first = 8'd2;
    ch_count = 8'd2;
    hs_cnt = 0;
    frame(16'h0000, 8, 15);
    wait_done(50, ok);
    check("sel_count", hs_cnt, 8);
    check("sel_q_empty", q.size(), 0);
    tick(2);
    // count clamped to the remaining channel
    ch_first = 8'd3;
    ch_count = 8'd5;
    hs_cnt = 0;
    frame(16'h0000, 12, 15);
    wait_done(50, ok);
    check("clamp_count", hs_cnt, 4);
    tick(2);
    // empty window: no words, done on the cycle after start
    ch_count = 8'd0;
    start = 1;
    tick(1);
    start = 0;
    check("empty_done", done, 1);
    check("empty_valid", m_valid, 0);
    check("empty_busy", busy, 0);
    tick(1);
    check("empty_done_end", done, 0);
    check("empty_valid_end", m_valid, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
